plru_replacer: RTL and testbench

Parametrised tree pseudo-LRU replacement unit for the L1 data/instruction caches. Holds NUM_WAYS-1 PLRU bits per set in flops and updates them on cache hits and on fills. On a victim request it returns a victim way one cycle later, preferring invalid ways. It sits beside the L1 tag array, between the tag-compare stage and the miss/fill path, and supports a multi-cycle flush.

---
 rtl/plru_replacer_pkg.sv | 26 ++
 rtl/plru_tree.sv | 49 ++++
 rtl/plru_replacer.sv | 126 ++++++++++++
 tb/tb_plru_replacer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/plru_replacer_pkg.sv
// Shared definitions for the tree pseudo-LRU replacement unit.
// Covers the node bit meaning, the FSM states and the default L1 geometry.
package plru_replacer_pkg;

  typedef enum logic {
    PLRU_LEFT  = 1'b0,
    PLRU_RIGHT = 1'b1
  } plru_node_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } flush_state_t;

  localparam int L1_NUM_WAYS = 4;
  localparam int L1_NUM_SETS = 64;

  // Depth of a heap-indexed node: level L holds nodes 2^L-1 .. 2^(L+1)-2.
  function automatic int plru_node_level(input int node);
    int lvl;
    lvl = 0;
    while (node >= (1 << (lvl + 1)) - 1) lvl++;
    return lvl;
  endfunction

endpackage

// File: rtl/plru_tree.sv
// Combinational PLRU tree for one set.
// Provides the victim walk over the current flags and the touch next-state for one way.
module plru_tree
  import plru_replacer_pkg::*;
#(
  parameter int NUM_WAYS = L1_NUM_WAYS,
  parameter int WAY_W    = $clog2(NUM_WAYS)
) (
  input  logic [NUM_WAYS-2:0] flags,
  input  logic [WAY_W-1:0]    touch_way,
  output logic [NUM_WAYS-2:0] touched,
  output logic [WAY_W-1:0]    victim
);

  int lvl;
  int pos;
  int prefix;
  logic dir;

  // A node lies on the path to a way when the way's top bits equal the node's position in its level.
  always_comb begin
    touched = flags;
    lvl     = 0;
    pos     = 0;
    for (int n = 0; n < NUM_WAYS - 1; n++) begin
      lvl = plru_node_level(n);
      pos = n - ((1 << lvl) - 1);
      if ((int'(touch_way) >> (WAY_W - lvl)) == pos) begin
        touched[n] = (((int'(touch_way) >> (WAY_W - 1 - lvl)) & 1) == 0) ? PLRU_RIGHT : PLRU_LEFT;
      end
    end
  end

  always_comb begin
    prefix = 0;
    dir    = 1'b0;
    for (int l = 0; l < WAY_W; l++) begin
      dir = 1'b0;
      for (int n = 0; n < NUM_WAYS - 1; n++) begin
        if (plru_node_level(n) == l && (n - ((1 << l) - 1)) == prefix) begin
          dir = (flags[n] == PLRU_RIGHT);
        end
      end
      prefix = prefix * 2 + int'(dir);
    end
    victim = prefix[WAY_W-1:0];
  end

endmodule

// File: rtl/plru_replacer.sv
// Tree pseudo-LRU replacement unit: per-set flag storage, hit/fill updates,
// one-cycle victim selection with update bypass, and a set-by-set flush sequencer.
module plru_replacer
  import plru_replacer_pkg::*;
#(
  parameter int NUM_WAYS = L1_NUM_WAYS,
  parameter int NUM_SETS = L1_NUM_SETS,
  parameter int WAY_W    = $clog2(NUM_WAYS),
  parameter int SET_W    = $clog2(NUM_SETS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                access_en,
  input  logic [SET_W-1:0]    access_set,
  input  logic [WAY_W-1:0]    access_way,
  input  logic                fill_en,
  input  logic [SET_W-1:0]    fill_set,
  input  logic [WAY_W-1:0]    fill_way,
  input  logic                vreq_valid,
  output logic                vreq_ready,
  input  logic [SET_W-1:0]    vreq_set,
  input  logic [NUM_WAYS-1:0] vreq_valid_mask,
  output logic                victim_valid,
  output logic [WAY_W-1:0]    victim_way,
  input  logic                flush_req,
  output logic                flush_busy
);

  logic [NUM_WAYS-2:0] flags [NUM_SETS];
  flush_state_t        state;
  logic [SET_W-1:0]    clear_cnt;

  logic                access_act, fill_act, accept, found;
  logic [NUM_WAYS-2:0] acc_next, fill_base, fill_next, byp_flags;
  logic [NUM_WAYS-2:0] byp_unused_touched;
  logic [WAY_W-1:0]    acc_unused_victim, fill_unused_victim;
  logic [WAY_W-1:0]    tree_victim, sel_way;

  assign access_act = access_en & ~flush_busy;
  assign fill_act   = fill_en & ~flush_busy;
  assign vreq_ready = ~flush_busy;
  assign accept     = vreq_valid & vreq_ready;

  // A same-set fill builds on the access result so the fill wins on shared nodes.
  assign fill_base = (access_act && access_set == fill_set) ? acc_next : flags[fill_set];

  always_comb begin
    byp_flags = flags[vreq_set];
    if (access_act && access_set == vreq_set) byp_flags = acc_next;
    if (fill_act && fill_set == vreq_set)     byp_flags = fill_next;
  end

  plru_tree #(.NUM_WAYS(NUM_WAYS), .WAY_W(WAY_W)) u_acc_tree (
    .flags(flags[access_set]), .touch_way(access_way),
    .touched(acc_next), .victim(acc_unused_victim)
  );

  plru_tree #(.NUM_WAYS(NUM_WAYS), .WAY_W(WAY_W)) u_fill_tree (
    .flags(fill_base), .touch_way(fill_way),
    .touched(fill_next), .victim(fill_unused_victim)
  );

  plru_tree #(.NUM_WAYS(NUM_WAYS), .WAY_W(WAY_W)) u_vic_tree (
    .flags(byp_flags), .touch_way('0),
    .touched(byp_unused_touched), .victim(tree_victim)
  );

  always_comb begin
    sel_way = tree_victim;
    found   = 1'b0;
    for (int i = 0; i < NUM_WAYS; i++) begin
      if (!vreq_valid_mask[i] && !found) begin
        sel_way = WAY_W'(i);
        found   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_SETS; s++) flags[s] <= '0;
    end else if (state == ST_FLUSH) begin
      flags[clear_cnt] <= '0;
    end else begin
      if (access_act) flags[access_set] <= acc_next;
      if (fill_act)   flags[fill_set]   <= fill_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      clear_cnt  <= '0;
      flush_busy <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (flush_req) begin
            state      <= ST_FLUSH;
            clear_cnt  <= '0;
            flush_busy <= 1'b1;
          end
        end
        ST_FLUSH: begin
          clear_cnt <= clear_cnt + 1'b1;
          if (clear_cnt == SET_W'(NUM_SETS - 1)) begin
            state      <= ST_IDLE;
            flush_busy <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      victim_valid <= 1'b0;
      victim_way   <= '0;
    end else begin
      victim_valid <= accept;
      if (accept) victim_way <= sel_way;
    end
  end

endmodule

// File: tb/tb_plru_replacer.sv
// Self-checking bench for plru_replacer: directed vector table, random traffic
// against a range-halving tree model, and hand-written flush/reset sequences.
module tb_plru_replacer;

  localparam int NW = 4;
  localparam int NS = 64;
  localparam int WW = 2;
  localparam int SW = 6;

  typedef struct {
    logic          acc_en;
    int            acc_set;
    int            acc_way;
    logic          fill_en;
    int            fill_set;
    int            fill_way;
    logic          req;
    int            req_set;
    logic [NW-1:0] mask;
    logic          exp_valid;
    int            exp_way;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          access_en, fill_en, vreq_valid, flush_req;
  logic [SW-1:0] access_set, fill_set, vreq_set;
  logic [WW-1:0] access_way, fill_way;
  logic [NW-1:0] vreq_valid_mask;
  logic          vreq_ready, victim_valid, flush_busy;
  logic [WW-1:0] victim_way;

  int passCount = 0;
  int checkCount = 0;
  int mflags [NS][NW-1];
  vec_t tbl [17];

  always #5 clk = ~clk;

  plru_replacer #(.NUM_WAYS(NW), .NUM_SETS(NS)) dut (
    .clk(clk), .rst_n(rst_n),
    .access_en(access_en), .access_set(access_set), .access_way(access_way),
    .fill_en(fill_en), .fill_set(fill_set), .fill_way(fill_way),
    .vreq_valid(vreq_valid), .vreq_ready(vreq_ready), .vreq_set(vreq_set),
    .vreq_valid_mask(vreq_valid_mask),
    .victim_valid(victim_valid), .victim_way(victim_way),
    .flush_req(flush_req), .flush_busy(flush_busy)
  );

  function automatic void modelClear();
    for (int s = 0; s < NS; s++)
      for (int n = 0; n < NW - 1; n++) mflags[s][n] = 0;
  endfunction

  // Halve the way range at each node; the node points to the half not containing w.
  function automatic void modelTouch(input int s, input int w);
    int node, lo, size, half;
    node = 0; lo = 0; size = NW;
    while (size > 1) begin
      half = size / 2;
      if (w < lo + half) begin
        mflags[s][node] = 1;
        node = 2 * node + 1;
      end else begin
        mflags[s][node] = 0;
        node = 2 * node + 2;
        lo = lo + half;
      end
      size = half;
    end
  endfunction

  function automatic int modelVictim(input int s, input logic [NW-1:0] mask);
    int node, lo, size, half;
    for (int i = 0; i < NW; i++) if (!mask[i]) return i;
    node = 0; lo = 0; size = NW;
    while (size > 1) begin
      half = size / 2;
      if (mflags[s][node] == 0) begin
        node = 2 * node + 1;
      end else begin
        node = 2 * node + 2;
        lo = lo + half;
      end
      size = half;
    end
    return lo;
  endfunction

  function automatic vec_t mk(input logic ae, input int as, input int aw,
                              input logic fe, input int fs, input int fw,
                              input logic rq, input int rs, input logic [NW-1:0] m,
                              input logic ev, input int ew);
    vec_t v;
    v.acc_en = ae; v.acc_set = as; v.acc_way = aw;
    v.fill_en = fe; v.fill_set = fs; v.fill_way = fw;
    v.req = rq; v.req_set = rs; v.mask = m;
    v.exp_valid = ev; v.exp_way = ew;
    return v;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual == expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  // Drives one cycle of traffic, updates the model in the same order as the hardware
  // should, and returns the victim the model predicts for this cycle's request.
  task automatic applyStimulus(input vec_t v, output logic expValid, output int expWay);
    access_en = v.acc_en; access_set = v.acc_set[SW-1:0]; access_way = v.acc_way[WW-1:0];
    fill_en = v.fill_en; fill_set = v.fill_set[SW-1:0]; fill_way = v.fill_way[WW-1:0];
    vreq_valid = v.req; vreq_set = v.req_set[SW-1:0]; vreq_valid_mask = v.mask;
    if (v.acc_en) modelTouch(v.acc_set, v.acc_way);
    if (v.fill_en) modelTouch(v.fill_set, v.fill_way);
    expValid = v.req;
    expWay = modelVictim(v.req_set, v.mask);
    @(posedge clk); #1;
  endtask

  task automatic idleInputs();
    access_en = 0; fill_en = 0; vreq_valid = 0; flush_req = 0;
    access_set = '0; access_way = '0; fill_set = '0; fill_way = '0;
    vreq_set = '0; vreq_valid_mask = '1;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic ev;
    int ew, busyCount;
    logic leak, timedOut;
    vec_t v;

    tbl[0]  = mk(0, 0, 0, 0, 0, 0, 1, 5, 4'b1111, 1, 0);
    tbl[1]  = mk(1, 5, 0, 0, 0, 0, 0, 0, 4'b1111, 0, 0);
    tbl[2]  = mk(1, 5, 2, 0, 0, 0, 0, 0, 4'b1111, 0, 0);
    tbl[3]  = mk(1, 5, 1, 0, 0, 0, 0, 0, 4'b1111, 0, 0);
    tbl[4]  = mk(0, 0, 0, 0, 0, 0, 1, 5, 4'b1111, 1, 3);
    tbl[5]  = mk(1, 6, 0, 0, 0, 0, 0, 0, 4'b1111, 0, 0);
    tbl[6]  = mk(0, 0, 0, 0, 0, 0, 1, 6, 4'b1111, 1, 2);
    tbl[7]  = mk(0, 0, 0, 0, 0, 0, 1, 9, 4'b1011, 1, 2);
    tbl[8]  = mk(1, 3, 0, 0, 0, 0, 1, 3, 4'b1111, 1, 2);
    tbl[9]  = mk(1, 7, 0, 1, 7, 2, 0, 0, 4'b1111, 0, 0);
    tbl[10] = mk(0, 0, 0, 0, 0, 0, 1, 7, 4'b1111, 1, 1);
    tbl[11] = mk(0, 0, 0, 0, 0, 0, 1, 5, 4'b1110, 1, 0);
    tbl[12] = mk(0, 0, 0, 0, 0, 0, 1, 5, 4'b1111, 1, 3);
    tbl[13] = mk(1, 20, 0, 1, 20, 1, 1, 20, 4'b1111, 1, 2);
    tbl[14] = mk(1, 21, 3, 1, 22, 1, 1, 21, 4'b1111, 1, 0);
    tbl[15] = mk(0, 0, 0, 0, 0, 0, 1, 22, 4'b1111, 1, 2);
    tbl[16] = mk(0, 0, 0, 1, 30, 0, 1, 30, 4'b1111, 1, 2);

    idleInputs();
    modelClear();
    rst_n = 1'b0;
    #12;
    checkOutput("reset victim_valid", int'(victim_valid), 0);
    checkOutput("reset victim_way", int'(victim_way), 0);
    checkOutput("reset flush_busy", int'(flush_busy), 0);
    checkOutput("reset vreq_ready", int'(vreq_ready), 1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    $display("[TB] directed vector table");
    for (int i = 0; i < 17; i++) begin
      applyStimulus(tbl[i], ev, ew);
      checkOutput($sformatf("vec%0d victim_valid", i), int'(victim_valid), int'(tbl[i].exp_valid));
      if (tbl[i].exp_valid)
        checkOutput($sformatf("vec%0d victim_way", i), int'(victim_way), tbl[i].exp_way);
    end

    $display("[TB] random traffic against model");
    for (int i = 0; i < 400; i++) begin
      v.acc_en = 1'($urandom_range(0, 1));
      v.acc_set = $urandom_range(0, 7);
      v.acc_way = $urandom_range(0, NW - 1);
      v.fill_en = 1'($urandom_range(0, 1));
      v.fill_set = $urandom_range(0, 7);
      v.fill_way = $urandom_range(0, NW - 1);
      v.req = 1'($urandom_range(0, 1));
      v.req_set = $urandom_range(0, 7);
      v.mask = ($urandom_range(0, 1) == 1) ? '1 : NW'($urandom);
      v.exp_valid = 0; v.exp_way = 0;
      applyStimulus(v, ev, ew);
      checkOutput($sformatf("rand%0d victim_valid", i), int'(victim_valid), int'(ev));
      if (ev) checkOutput($sformatf("rand%0d victim_way", i), int'(victim_way), ew);
    end

    $display("[TB] flush sequence");
    applyStimulus(mk(1, 12, 0, 0, 0, 0, 0, 0, 4'b1111, 0, 0), ev, ew);
    idleInputs();
    flush_req = 1'b1;
    @(posedge clk); #1;
    flush_req = 1'b0;
    checkOutput("flush_busy after flush_req", int'(flush_busy), 1);
    checkOutput("vreq_ready during flush", int'(vreq_ready), 0);
    busyCount = 1; leak = 1'b0; timedOut = 1'b1;
    vreq_valid = 1'b1; vreq_set = 12; vreq_valid_mask = '1;
    for (int c = 0; c < 200; c++) begin
      access_en = (busyCount == 30);
      access_set = 12; access_way = 0;
      @(posedge clk); #1;
      if (victim_valid) leak = 1'b1;
      if (!flush_busy) begin
        timedOut = 1'b0;
        break;
      end
      busyCount++;
    end
    access_en = 1'b0;
    modelClear();
    checkOutput("flush completed within bound", int'(timedOut), 0);
    checkOutput("flush_busy cycle count", busyCount, NS);
    checkOutput("no victim while flushing", int'(leak), 0);
    checkOutput("vreq_ready after flush", int'(vreq_ready), 1);
    @(posedge clk); #1;
    vreq_valid = 1'b0;
    checkOutput("post-flush victim_valid", int'(victim_valid), 1);
    checkOutput("post-flush set12 victim_way", int'(victim_way), modelVictim(12, 4'b1111));
    checkOutput("post-flush set12 victim is 0", int'(victim_way), 0);

    $display("[TB] reset during flush");
    applyStimulus(mk(1, 5, 0, 0, 0, 0, 0, 0, 4'b1111, 0, 0), ev, ew);
    idleInputs();
    flush_req = 1'b1;
    @(posedge clk); #1;
    flush_req = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("mid-flush reset flush_busy", int'(flush_busy), 0);
    checkOutput("mid-flush reset victim_valid", int'(victim_valid), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    modelClear();
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 1, 5, 4'b1111, 0, 0), ev, ew);
    checkOutput("after reset set5 victim_valid", int'(victim_valid), 1);
    checkOutput("after reset set5 victim_way", int'(victim_way), 0);
    idleInputs();
    @(posedge clk); #1;
    checkOutput("victim_valid single-cycle", int'(victim_valid), 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
